// File: rtl/iq_serializer_param.sv
// Framed I/Q serializer: double-buffered sample pairs shifted out as sync + I + Q with a divided bit clock.
// Optional build macro IQSER_PARITY_EN appends one even-parity bit over I and Q after Q.
module iq_serializer_param #(
    parameter int          DATA_W       = 14,
    parameter int          SYNC_W       = 4,
    parameter logic [7:0]  SYNC_PATTERN = 8'b0000_1010,
    parameter int          CLK_DIV      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] q_data,
    input  logic              overrun_clr,
    output logic              serial,
    output logic              serial_n,
    output logic              serial_clk,
    output logic              frame_active,
    output logic              frame_done,
    output logic              overrun
);

`ifdef IQSER_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FL     = SYNC_W + 2 * DATA_W + PAR_W;
    localparam int SW_EFF = (SYNC_W == 0) ? 1 : SYNC_W;
    localparam int BIT_W  = $clog2(FL);
    localparam int DIV_W  = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
    localparam state_t FIRST_STATE = (SYNC_W == 0) ? DATA : SYNC;

    state_t            state, state_next;
    logic              hold_full;
    logic [DATA_W-1:0] i_hold, q_hold;
    logic [FL-1:0]     shreg;
    logic              ser_q, ser_n_q, sclk_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              overrun_q;

    logic                                 wrap, last, load, accept, drop;
    logic [FL-1:0]                        frame_word;
    logic [SW_EFF+2*DATA_W+PAR_W-1:0]     frame_full;

    // With no header the padded sync bit sits above FL and is sliced away.
    always_comb begin
`ifdef IQSER_PARITY_EN
        frame_full = {SYNC_PATTERN[SW_EFF-1:0], i_hold, q_hold, ^{i_hold, q_hold}};
`else
        frame_full = {SYNC_PATTERN[SW_EFF-1:0], i_hold, q_hold};
`endif
        frame_word = frame_full[FL-1:0];
    end

    assign wrap   = (state != IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last   = (bit_cnt == BIT_W'(FL - 1));
    assign load   = hold_full && ((state == IDLE) || (wrap && last));
    assign accept = in_valid && !hold_full;
    assign drop   = in_valid && hold_full;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (hold_full) state_next = FIRST_STATE;
            SYNC, DATA: begin
                if (wrap) begin
                    if (last)
                        state_next = hold_full ? FIRST_STATE : IDLE;
                    else if ((state == SYNC) && (bit_cnt == BIT_W'(SYNC_W - 1)))
                        state_next = DATA;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            i_hold    <= '0;
            q_hold    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (accept) begin
                hold_full <= 1'b1;
                i_hold    <= i_data;
                q_hold    <= q_data;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (drop)             overrun_q <= 1'b1;
            else if (overrun_clr) overrun_q <= 1'b0;
        end
    end

    // serial and serial_n share one register stage so the LVDS pair stays aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            ser_q   <= 1'b0;
            ser_n_q <= 1'b1;
            sclk_q  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= frame_word << 1;
            ser_q   <= frame_word[FL-1];
            ser_n_q <= ~frame_word[FL-1];
            sclk_q  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (wrap && last) begin
            ser_q   <= 1'b0;
            ser_n_q <= 1'b1;
            sclk_q  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (wrap) begin
            shreg   <= shreg << 1;
            ser_q   <= shreg[FL-1];
            ser_n_q <= ~shreg[FL-1];
            sclk_q  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= bit_cnt + BIT_W'(1);
        end else if (state != IDLE) begin
            div_cnt <= div_cnt + DIV_W'(1);
            sclk_q  <= (div_cnt + DIV_W'(1)) >= DIV_W'(CLK_DIV / 2);
        end
    end

    assign in_ready     = ~hold_full;
    assign serial       = ser_q;
    assign serial_n     = ser_n_q;
    assign serial_clk   = sclk_q;
    assign frame_active = (state != IDLE);
    assign frame_done   = wrap && last;
    assign overrun      = overrun_q;

endmodule

// File: doc/iq_serializer_param.md
Name: iq_serializer_param

Overview:
Parametrised I/Q serializer for the LoRa modulator datapath. It accepts I/Q sample pairs through a valid/ready handshake and double-buffers them. Each pair is shifted out as a framed serial bitstream: sync header, then I MSB-first, then Q MSB-first. The block also drives a divided bit clock and a complementary output for the LVDS radio interface. It replaces the fixed-width serializer and adds configurable width, sync framing, bit-rate division, back-pressure and overrun reporting.

Parameters:
DATA_W, 14, width of each of I and Q in bits (2..16)
SYNC_W, 4, sync header length in bits (0..8; 0 = no header)
SYNC_PATTERN, 4'b1010, header bits, sent MSB first (low SYNC_W bits are used)
CLK_DIV, 4, clk cycles per serial bit (even, >=2)

Ports:
clk  in  1  bit-rate source clock (PLL output)
rst  in  1  asynchronous reset, active-high
in_valid  in  1  I/Q pair presented
in_ready  out  1  holding buffer empty; pair accepted when in_valid && in_ready
i_data  in  DATA_W  I sample, two's complement
q_data  in  DATA_W  Q sample, two's complement
overrun_clr  in  1  clears sticky overrun
serial  out  1  serial data
serial_n  out  1  complement of serial
serial_clk  out  1  bit clock; rising edge at mid-bit
frame_active  out  1  a frame is being shifted
frame_done  out  1  one-cycle pulse on the last cycle of a frame
overrun  out  1  sticky flag: in_valid asserted while in_ready low

Behaviour:
- Reset values: in_ready=1, serial=0, serial_n=1, serial_clk=0, frame_active=0, frame_done=0, overrun=0. Hold buffer and shifter are empty, all counters are 0, state is IDLE.
- Frame length FL = SYNC_W + 2*DATA_W bits (+1 with the optional feature). Frame duration is FL*CLK_DIV cycles.
- Hold buffer: one entry. in_ready = ~hold_full (registered flag).
  - Accept on edge N: hold_full=1.
  - Hold is drained into the shifter on a load edge, which clears hold_full.
  - Simultaneous accept and load cannot occur because in_ready is low while full.
- FSM states: IDLE, SYNC, DATA.
  - IDLE: on the first edge with hold_full=1, load the shifter with {SYNC, I, Q}. Go to SYNC, or to DATA if SYNC_W=0.
  - Latency: accept edge N -> first bit on serial after edge N+1; frame_active=1 from edge N+1.
  - SYNC -> DATA after SYNC_W bit periods.
  - DATA -> IDLE after 2*DATA_W bit periods if hold is empty. If hold is full, reload on the same edge and enter SYNC/DATA with zero gap (back-to-back frames).
- Bit timing: div_cnt runs 0..CLK_DIV-1 during a frame. serial updates only when div_cnt wraps to 0. serial_clk=0 for div_cnt<CLK_DIV/2 and 1 otherwise (registered, aligned with serial). Receiver samples on the serial_clk rising edge.
- Idle: serial=0, serial_n=1, serial_clk=0, div_cnt held at 0.
- frame_done: high for the single cycle where bit_cnt=FL-1 and div_cnt=CLK_DIV-1.
- overrun: set on any cycle with in_valid=1 && in_ready=0; the offered data is dropped. Cleared by overrun_clr, unless a new overrun occurs in the same cycle (set wins).
- Reset mid-frame: all state returns to reset values immediately (async). The partial frame and any held pair are discarded.
- serial_n is always ~serial; both come from the same register stage (no skew between them).

Optional Feature:
Macro IQSER_PARITY_EN.
- Defined: one even-parity bit, computed over all I and Q bits, is appended after Q. FL = SYNC_W + 2*DATA_W + 1, and frame_done moves one bit period later.
- Undefined: no parity bit; FL = SYNC_W + 2*DATA_W.

Test Plan:
- Defaults, I=14'h2AB5, Q=14'h1F03 accepted at edge N -> serial emits 1010, then 10101010110101, then 01111100000011. Each bit lasts 4 cycles; serial_clk rises at cycle 2 of each bit; frame_done at N+128; frame_active low after that.
- Two pairs, the second offered when in_ready rises -> second frame's sync bit begins on the cycle after the first frame's frame_done, with no idle gap; 256 active cycles total.
- in_valid held high during a frame with hold already full -> overrun=1 and stays set; the dropped pair never appears; overrun_clr pulse -> overrun=0.
- rst asserted at bit 10 of a frame -> outputs immediately at reset values, in_ready=1; a new pair after release frames correctly from its sync bit.
- SYNC_W=0, CLK_DIV=2, DATA_W=4, I=4'h9, Q=4'h6 -> serial 10010110, frame_done 16 cycles after load.
- IQSER_PARITY_EN, I=14'h0001, Q=14'h0000 -> 33rd bit = 1; with Q=14'h0001 -> 33rd bit = 0.
